start_seq_gen: RTL and testbench

Generates the experiment timing pulses that the photon/stop counter consumes: a periodic `start` train, plus a `start_rst` / `photo_rst1` pulse pair at each sequence boundary. Runs in the 500 MHz domain.
- Pulse widths are at least 2 cycles, so the counter's 2-sample rising-edge detectors always catch them.
- Configuration comes from PC registers and is latched at run start.
- Reports its progress through `seq_cnt`, `start_cnt`, `busy` and `done`.

---
 rtl/start_seq_pkg.sv | 14 +
 rtl/start_period_timer.sv | 23 ++
 rtl/start_seq_gen.sv | 102 ++++++++++
 tb/tb_start_seq_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/start_seq_pkg.sv
// start_seq_pkg: shared states, minimum timings and config clamps for start_seq_gen
package start_seq_pkg;
  typedef enum logic [2:0] {IDLE, HIGH, LOW, SEQRST, DONE} state_t;
  localparam int MIN_PERIOD = 4;
  localparam int MIN_HIGH = 2;
  function automatic logic [31:0] clamp_p(input logic [31:0] period);
    return period < 32'(MIN_PERIOD) ? 32'(MIN_PERIOD) : period;
  endfunction
  function automatic logic [31:0] clamp_h(input logic [31:0] high_len, input logic [31:0] p);
    logic [31:0] h;
    h = high_len < 32'(MIN_HIGH) ? 32'(MIN_HIGH) : high_len;
    return h > p - 32'd2 ? p - 32'd2 : h;
  endfunction
endpackage

// File: rtl/start_period_timer.sv
// start_period_timer: phase counter 0..P-1 with high-end and period-end flags
module start_period_timer
  import start_seq_pkg::*;
#(
  parameter int W_PER = 32
) (
  input  logic             clk500,
  input  logic             count_rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [W_PER-1:0] p,
  input  logic [W_PER-1:0] h,
  output logic [W_PER-1:0] ph,
  output logic             hi_end,
  output logic             per_end
);
  assign hi_end = ph == h - 1'b1;
  assign per_end = ph == p - 1'b1;
  // phase advances while enabled and restarts at the period end so it never passes P-1
  always_ff @(posedge clk500 or negedge count_rst_n)
    if (!count_rst_n) ph <= '0;
    else ph <= load || (en && per_end) ? '0 : en ? ph + 1'b1 : ph;
endmodule

// File: rtl/start_seq_gen.sv
// start_seq_gen: periodic start train with start_rst/photo_rst1 pulses at sequence boundaries
module start_seq_gen
  import start_seq_pkg::*;
#(
  parameter int W_PER   = 32,
  parameter int W_ST    = 24,
  parameter int W_SEQ   = 32,
  parameter int RST_LEN = 4
) (
  input  logic             clk500,
  input  logic             count_rst_n,
  input  logic             run,
  input  logic             abort,
  input  logic [W_PER-1:0] period,
  input  logic [W_PER-1:0] high_len,
  input  logic [W_ST-1:0]  starts_per_seq,
  input  logic [W_SEQ-1:0] num_seq,
  output logic             start,
  output logic             start_rst,
  output logic             photo_rst1,
  output logic [W_ST-1:0]  start_cnt,
  output logic [W_SEQ-1:0] seq_cnt,
  output logic             busy,
  output logic             done
);
  state_t st, nx;
  logic [W_PER-1:0] p_q, h_q, ph;
  logic [W_ST-1:0] s_q;
  logic [W_SEQ-1:0] n_q;
  logic [7:0] rc;
  logic hi_end, per_end, go, st_last, seq_last, rst_end;
  assign st_last = W_ST'(start_cnt + 1'b1) == s_q;
  assign seq_last = n_q != '0 && W_SEQ'(seq_cnt + 1'b1) == n_q;
  assign rst_end = rc == 8'(RST_LEN - 1);
  assign go = st == IDLE && nx == HIGH;
  start_period_timer #(.W_PER(W_PER)) u_timer (
    .clk500(clk500),
    .count_rst_n(count_rst_n),
    .load(go),
    .en(st == HIGH || st == LOW),
    .p(p_q),
    .h(h_q),
    .ph(ph),
    .hi_end(hi_end),
    .per_end(per_end)
  );
  // next state; abort overrides every other transition
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = run ? HIGH : IDLE;
      HIGH:    nx = hi_end ? LOW : HIGH;
      LOW:     nx = per_end ? (st_last ? SEQRST : HIGH) : LOW;
      SEQRST:  nx = rst_end ? (seq_last ? DONE : HIGH) : SEQRST;
      DONE:    nx = run ? DONE : IDLE;
      default: nx = IDLE;
    endcase
    if (abort) nx = IDLE;
  end
  // state, frozen config, boundary-pulse length and progress counters
  always_ff @(posedge clk500 or negedge count_rst_n)
    if (!count_rst_n) begin
      st <= IDLE;
      p_q <= '0;
      h_q <= '0;
      s_q <= '0;
      n_q <= '0;
      rc <= '0;
      start_cnt <= '0;
      seq_cnt <= '0;
    end else begin
      st <= nx;
      rc <= st == SEQRST && !rst_end ? rc + 1'b1 : '0;
      if (go) begin
        p_q <= W_PER'(clamp_p(32'(period)));
        h_q <= W_PER'(clamp_h(32'(high_len), clamp_p(32'(period))));
        s_q <= starts_per_seq == '0 ? W_ST'(1) : starts_per_seq;
        n_q <= num_seq;
        start_cnt <= '0;
        seq_cnt <= '0;
      end else if (!abort && st == LOW && per_end) start_cnt <= start_cnt + 1'b1;
      else if (!abort && st == SEQRST && rst_end) begin
        seq_cnt <= seq_cnt + 1'b1;
        start_cnt <= '0;
      end
    end
  // registered pulse and status outputs, forced low the cycle after abort
  always_ff @(posedge clk500 or negedge count_rst_n)
    if (!count_rst_n) begin
      start <= 1'b0;
      start_rst <= 1'b0;
      photo_rst1 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      start <= st == HIGH && !abort;
      start_rst <= st == SEQRST && !abort;
      photo_rst1 <= st == SEQRST && !abort;
      busy <= (st == HIGH || st == LOW || st == SEQRST) && !abort;
      done <= st == DONE && !abort;
    end
endmodule

// File: tb/tb_start_seq_gen.sv
// tb_start_seq_gen: directed checks of start_seq_gen pulse timing, clamps, abort and reset
module tb_start_seq_gen;
  import start_seq_pkg::*;
  logic clk500 = 1'b0, count_rst_n = 1'b0, run = 1'b0, abort = 1'b0;
  logic [31:0] period = '0, high_len = '0, num_seq = '0;
  logic [23:0] starts_per_seq = '0;
  logic start, start_rst, photo_rst1, busy, done;
  logic [23:0] start_cnt;
  logic [31:0] seq_cnt;
  logic start2, start_rst2, photo_rst12, busy2, done2;
  logic [23:0] start_cnt2;
  logic [2:0] seq_cnt2;
  logic [63:0] sv, rv, pv, bv, dv;
  logic mon = 1'b0, done_seen;
  int n_cmp = 0, n_bad = 0;

  start_seq_gen dut (
    .clk500(clk500), .count_rst_n(count_rst_n), .run(run), .abort(abort),
    .period(period), .high_len(high_len), .starts_per_seq(starts_per_seq), .num_seq(num_seq),
    .start(start), .start_rst(start_rst), .photo_rst1(photo_rst1),
    .start_cnt(start_cnt), .seq_cnt(seq_cnt), .busy(busy), .done(done)
  );

  start_seq_gen #(.W_SEQ(3)) dut2 (
    .clk500(clk500), .count_rst_n(count_rst_n), .run(run), .abort(abort),
    .period(period), .high_len(high_len), .starts_per_seq(starts_per_seq), .num_seq(num_seq[2:0]),
    .start(start2), .start_rst(start_rst2), .photo_rst1(photo_rst12),
    .start_cnt(start_cnt2), .seq_cnt(seq_cnt2), .busy(busy2), .done(done2)
  );

  always #5 clk500 = ~clk500;

  always @(negedge clk500) done_seen <= mon ? (done_seen | done | done2) : 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [31:0] p, input logic [31:0] h, input logic [23:0] s, input logic [31:0] n);
    period = p;
    high_len = h;
    starts_per_seq = s;
    num_seq = n;
  endtask

  task automatic capture(input int n, input int abort_at, input int chg_at);
    sv = '0; rv = '0; pv = '0; bv = '0; dv = '0;
    @(negedge clk500);
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk500);
      run = 1'b0;
      abort = i == abort_at;
      if (i == chg_at) begin
        period = 20;
        high_len = 7;
      end
      sv[i] = start;
      rv[i] = start_rst;
      pv[i] = photo_rst1;
      bv[i] = busy;
      dv[i] = done;
    end
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk500);
    chk("rst_pulses", 64'({start, start_rst, photo_rst1, busy, done}), 64'd0);
    chk("rst_start_cnt", 64'(start_cnt), 64'd0);
    chk("rst_seq_cnt", 64'(seq_cnt), 64'd0);
    count_rst_n = 1'b1;
    repeat (2) @(negedge clk500);

    cfg(10, 3, 2, 1);
    capture(30, -1, -1);
    chk("basic_start", sv, 64'h380E);
    chk("basic_start_rst", rv, 64'h1E0_0000);
    chk("basic_photo_rst1", pv, 64'h1E0_0000);
    chk("basic_busy", bv, 64'h1FF_FFFE);
    chk("basic_done", dv, 64'h200_0000);
    chk("basic_seq_cnt", 64'(seq_cnt), 64'd1);
    chk("basic_start_cnt", 64'(start_cnt), 64'd0);

    cfg(1, 0, 3, 1);
    capture(24, -1, -1);
    chk("clamp_start", sv, 64'h666);
    chk("clamp_start_rst", rv, 64'h1_E000);
    chk("clamp_done", dv, 64'h2_0000);
    chk("clamp_seq_cnt", 64'(seq_cnt), 64'd1);

    cfg(4, 0, 1, 0);
    mon = 1'b1;
    @(negedge clk500);
    run = 1'b1;
    @(negedge clk500);
    run = 1'b0;
    repeat (8) @(negedge clk500);
    chk("unl_seq_1", 64'(seq_cnt), 64'd1);
    chk("unl_seq_busy", 64'(busy), 64'd1);
    repeat (48) @(negedge clk500);
    chk("unl_seq_7", 64'(seq_cnt), 64'd7);
    chk("unl_w3_seq_7", 64'(seq_cnt2), 64'd7);
    repeat (8) @(negedge clk500);
    chk("unl_seq_8", 64'(seq_cnt), 64'd8);
    chk("unl_w3_wrap", 64'(seq_cnt2), 64'd0);
    chk("unl_no_done", 64'(done_seen), 64'd0);
    mon = 1'b0;
    abort = 1'b1;
    @(negedge clk500);
    abort = 1'b0;
    chk("unl_abort_busy", 64'(busy), 64'd0);
    chk("unl_abort_seq_hold", 64'(seq_cnt), 64'd8);
    chk("unl_abort_state", 64'(dut.st), 64'(IDLE));

    cfg(10, 3, 3, 1);
    capture(20, 11, -1);
    chk("abort_start", sv, 64'h80E);
    chk("abort_busy", bv, 64'hFFE);
    chk("abort_start_cnt", 64'(start_cnt), 64'd1);
    chk("abort_seq_cnt", 64'(seq_cnt), 64'd0);
    chk("abort_state", 64'(dut.st), 64'(IDLE));
    @(negedge clk500);
    run = 1'b1;
    @(negedge clk500);
    run = 1'b0;
    chk("rerun_clear", 64'(start_cnt), 64'd0);
    abort = 1'b1;
    @(negedge clk500);
    abort = 1'b0;
    @(negedge clk500);

    cfg(10, 3, 3, 1);
    capture(40, -1, 4);
    chk("freeze_start", sv, 64'hE0_380E);
    chk("freeze_start_rst", rv, 64'h7_8000_0000);
    chk("freeze_done", dv, 64'h8_0000_0000);
    chk("freeze_seq_cnt", 64'(seq_cnt), 64'd1);

    cfg(4, 0, 1, 1);
    capture(6, -1, -1);
    chk("ares_pre_rst", rv, 64'h20);
    chk("ares_pre_busy", 64'(busy), 64'd1);
    #2;
    count_rst_n = 1'b0;
    #1;
    chk("ares_pulses", 64'({start_rst, photo_rst1, busy}), 64'd0);
    chk("ares_start_cnt", 64'(start_cnt), 64'd0);
    chk("ares_state", 64'(dut.st), 64'(IDLE));
    @(negedge clk500);
    count_rst_n = 1'b1;
    repeat (5) @(negedge clk500);
    chk("ares_idle", 64'({start, start_rst, busy, done}), 64'd0);
    chk("ares_idle_seq", 64'(seq_cnt), 64'd0);

    cfg(10, 3, 2, 1);
    capture(30, -1, -1);
    chk("recover_start", sv, 64'h380E);
    chk("recover_done", dv, 64'h200_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
